// File: rtl/lcd_fb_scheduler_if.sv
// ---------------------------------------------------------------------------
// lcd_fb_scheduler_if
// Bundles the host access handshake and the shared frame-memory bus used by
// lcd_fb_scheduler.
//   iHOST_REQ   : host access request, held until acknowledged
//   iHOST_WE    : 1 = write, 0 = read
//   iHOST_ADDR  : host word address (19 bit)
//   iHOST_WDATA : host write data (16 bit)
//   oHOST_ACK   : one-cycle completion pulse
//   oHOST_RDATA : host read data, valid while oHOST_ACK = 1
//   oMEM_ADDR   : shared frame-memory address (19 bit)
//   oMEM_WE     : memory write enable
//   oMEM_WDATA  : memory write data (16 bit)
//   iMEM_RDATA  : memory read data, valid one cycle after the address
// Modports:
//   slave  - the scheduler's view (it serves the host and masters the memory)
//   master - the environment's view (host + memory model)
// ---------------------------------------------------------------------------
interface lcd_fb_scheduler_if;
  logic        iHOST_REQ;
  logic        iHOST_WE;
  logic [18:0] iHOST_ADDR;
  logic [15:0] iHOST_WDATA;
  logic        oHOST_ACK;
  logic [15:0] oHOST_RDATA;
  logic [18:0] oMEM_ADDR;
  logic        oMEM_WE;
  logic [15:0] oMEM_WDATA;
  logic [15:0] iMEM_RDATA;

  modport slave (
    input  iHOST_REQ, iHOST_WE, iHOST_ADDR, iHOST_WDATA, iMEM_RDATA,
    output oHOST_ACK, oHOST_RDATA, oMEM_ADDR, oMEM_WE, oMEM_WDATA
  );

  modport master (
    output iHOST_REQ, iHOST_WE, iHOST_ADDR, iHOST_WDATA, iMEM_RDATA,
    input  oHOST_ACK, oHOST_RDATA, oMEM_ADDR, oMEM_WE, oMEM_WDATA
  );
endinterface

// File: rtl/lcd_fb_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_fb_scheduler
// Single-port frame-memory arbiter between the LCD display fetch (burst reads
// into an external pixel FIFO) and a host read/write port.
// Ports:
//   iCLK        : single clock
//   iRST        : synchronous, active-high reset
//   iVSYNC      : one-cycle frame-start pulse (restarts the fetch pointer)
//   iFIFO_LEVEL : current external pixel FIFO occupancy (10 bit)
//   oFIFO_WR    : pixel FIFO write strobe
//   oFIFO_DATA  : pixel word to FIFO (16 bit)
//   oBUSY       : arbiter not idle
//   bus         : host handshake + memory bus (lcd_fb_scheduler_if.slave)
// ---------------------------------------------------------------------------
module lcd_fb_scheduler #(
  parameter int unsigned H_ACT      = 800,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned BURST      = 16,
  parameter int unsigned LOW_WM     = 64,
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVSYNC,
  input  logic [9:0]        iFIFO_LEVEL,
  output logic              oFIFO_WR,
  output logic [15:0]       oFIFO_DATA,
  output logic              oBUSY,
  lcd_fb_scheduler_if.slave bus
);

  localparam int unsigned FRAME_WORDS = H_ACT * V_ACT;
  localparam int unsigned CW          = $clog2(BURST + 1);

  localparam logic [18:0]   FRAME_FC = 19'(FRAME_WORDS);
  localparam logic [18:0]   FP_LAST  = 19'(FRAME_WORDS - 1);
  localparam logic [9:0]    LOW_WM_L = 10'(LOW_WM);
  localparam logic [9:0]    OPP_WM_L = 10'(FIFO_DEPTH - BURST);
  localparam logic [CW-1:0] BURST_C  = CW'(BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISP_BURST,
    S_HOST_ACC,
    S_HOST_WAIT
  } state_t;

  state_t        r_state;
  logic [18:0]   r_fp;        // next display word to fetch
  logic [18:0]   r_fc;        // display words fetched this frame
  logic [CW-1:0] r_cnt;       // addresses issued in the current burst
  logic          r_pend;      // vsync seen, not yet serviced
  logic          r_busy;
  logic          r_fifo_wr;
  logic          r_ack;
  logic [18:0]   r_mem_addr;
  logic          r_mem_we;
  logic [15:0]   r_mem_wdata;

  logic [18:0]   w_fp_next;
  logic [18:0]   w_fc_next;
  logic          w_frame_left;
  logic          w_urgent;
  logic          w_opp;
  logic          w_grant_disp;
  logic          w_burst_done;
  logic          w_issue;

  always_comb begin
    w_fp_next    = (r_fp == FP_LAST) ? '0 : r_fp + 19'd1;
    w_fc_next    = r_fc + 19'd1;
    w_frame_left = (r_fc < FRAME_FC);
    w_urgent     = w_frame_left && (iFIFO_LEVEL <= LOW_WM_L);
    w_opp        = w_frame_left && (iFIFO_LEVEL <= OPP_WM_L);
    // Host outranks opportunistic fetch, so once the FIFO is above the low
    // watermark a waiting host always wins the next grant after a burst.
    w_grant_disp = w_urgent || (!bus.iHOST_REQ && w_opp);
    // r_fc already counts the address on the bus this cycle.
    w_burst_done = (r_cnt == BURST_C) || (r_fc == FRAME_FC);
    w_issue      = ((r_state == S_IDLE) && !r_pend && w_grant_disp) ||
                   ((r_state == S_DISP_BURST) && !w_burst_done);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= S_IDLE;
      r_fp        <= '0;
      r_fc        <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_busy      <= 1'b0;
      r_fifo_wr   <= 1'b0;
      r_ack       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      // Every address issued in a burst cycle yields a FIFO word next cycle,
      // including the last one after the FSM has already left the burst.
      r_fifo_wr   <= (r_state == S_DISP_BURST);
      r_ack       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;

      if (iVSYNC) begin
        r_pend <= 1'b1;
      end

      if (w_issue) begin
        r_mem_addr <= r_fp;
        r_fp       <= w_fp_next;
        r_fc       <= w_fc_next;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_fp   <= '0;
            r_fc   <= '0;
            r_pend <= iVSYNC;
          end else if (w_grant_disp) begin
            r_state <= S_DISP_BURST;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(1);
          end else if (bus.iHOST_REQ) begin
            r_state     <= S_HOST_ACC;
            r_busy      <= 1'b1;
            r_mem_addr  <= bus.iHOST_ADDR;
            r_mem_we    <= bus.iHOST_WE;
            r_mem_wdata <= bus.iHOST_WDATA;
          end
        end
        S_DISP_BURST: begin
          if (w_burst_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOST_ACC: begin
          r_state <= S_HOST_WAIT;
          r_ack   <= 1'b1;
        end
        S_HOST_WAIT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory read data arrives one cycle after the address, aligned with the
  // registered strobes, so it is forwarded under those strobes.
  assign oFIFO_WR        = r_fifo_wr;
  assign oFIFO_DATA      = r_fifo_wr ? bus.iMEM_RDATA : '0;
  assign oBUSY           = r_busy;
  assign bus.oHOST_ACK   = r_ack;
  assign bus.oHOST_RDATA = r_ack ? bus.iMEM_RDATA : '0;
  assign bus.oMEM_ADDR   = r_mem_addr;
  assign bus.oMEM_WE     = r_mem_we;
  assign bus.oMEM_WDATA  = r_mem_wdata;

endmodule

// File: tb/tb_lcd_fb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_fb_scheduler
// Directed bench for lcd_fb_scheduler. dut uses the full 800x480 frame;
// dut2 uses a 26-word frame so the end-of-frame stop and pointer wrap are
// reached in a few cycles.
// ---------------------------------------------------------------------------
module tb_lcd_fb_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vsync, fifo_wr, busy;
  logic [9:0]  level;
  logic [15:0] fifo_data;
  logic        rst2, vsync2, fifo_wr2, busy2;
  logic [9:0]  level2;
  logic [15:0] fifo_data2;

  lcd_fb_scheduler_if bif();
  lcd_fb_scheduler_if bif2();

  lcd_fb_scheduler dut (
    .iCLK(clk), .iRST(rst), .iVSYNC(vsync), .iFIFO_LEVEL(level),
    .oFIFO_WR(fifo_wr), .oFIFO_DATA(fifo_data), .oBUSY(busy), .bus(bif)
  );

  lcd_fb_scheduler #(.H_ACT(26), .V_ACT(1)) dut2 (
    .iCLK(clk), .iRST(rst2), .iVSYNC(vsync2), .iFIFO_LEVEL(level2),
    .oFIFO_WR(fifo_wr2), .oFIFO_DATA(fifo_data2), .oBUSY(busy2), .bus(bif2)
  );

  function automatic logic [15:0] pat(input logic [18:0] a);
    return a[15:0] ^ {a[18:16], 13'h0A5};
  endfunction

  // Memory model: synchronous read, one written location remembered.
  logic [15:0] rdata1, rdata2, wr_data;
  logic [18:0] wr_addr;
  logic        wr_valid = 1'b0;

  always @(posedge clk) begin
    rdata1 <= (wr_valid && wr_addr == bif.oMEM_ADDR) ? wr_data : pat(bif.oMEM_ADDR);
    if (bif.oMEM_WE) begin
      wr_valid <= 1'b1;
      wr_addr  <= bif.oMEM_ADDR;
      wr_data  <= bif.oMEM_WDATA;
    end
    rdata2 <= pat(bif2.oMEM_ADDR);
  end

  assign bif.iMEM_RDATA  = rdata1;
  assign bif2.iMEM_RDATA = rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1; rst2 = 1'b1; vsync = 1'b0; vsync2 = 1'b0;
    level = 10'd500; level2 = 10'd500;
    bif.iHOST_REQ = 1'b0; bif.iHOST_WE = 1'b0; bif.iHOST_ADDR = '0; bif.iHOST_WDATA = '0;
    bif2.iHOST_REQ = 1'b0; bif2.iHOST_WE = 1'b0; bif2.iHOST_ADDR = '0; bif2.iHOST_WDATA = '0;
    tick; tick;
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_addr",    32'(bif.oMEM_ADDR), 32'd0);
    chk("rst_ack",     32'(bif.oHOST_ACK), 32'd0);
    chk("rst2_busy",   32'(busy2), 32'd0);

    rst = 1'b0;
    tick; tick;
    chk("idle_hi_level", 32'(busy), 32'd0);

    // Single urgent burst, no host.
    level = 10'd10;
    tick;
    level = 10'd500;
    for (int i = 0; i < 16; i++) begin
      chk("b0_busy", 32'(busy), 32'd1);
      chk("b0_addr", 32'(bif.oMEM_ADDR), 32'(i));
      chk("b0_we",   32'(bif.oMEM_WE), 32'd0);
      if (i == 0) begin
        chk("b0_wr_first", 32'(fifo_wr), 32'd0);
      end else begin
        chk("b0_wr",   32'(fifo_wr), 32'd1);
        chk("b0_data", 32'(fifo_data), 32'(pat(19'(i - 1))));
      end
      tick;
    end
    chk("b0_wr_last",   32'(fifo_wr), 32'd1);
    chk("b0_data_last", 32'(fifo_data), 32'(pat(19'd15)));
    chk("b0_idle",      32'(busy), 32'd0);
    tick;
    chk("b0_wr_off", 32'(fifo_wr), 32'd0);

    // Host read at level 100, then opportunistic burst.
    level = 10'd100;
    bif.iHOST_REQ = 1'b1; bif.iHOST_WE = 1'b0; bif.iHOST_ADDR = 19'h12345;
    tick;
    chk("h_acc_busy", 32'(busy), 32'd1);
    chk("h_acc_addr", 32'(bif.oMEM_ADDR), 32'h12345);
    chk("h_acc_we",   32'(bif.oMEM_WE), 32'd0);
    chk("h_acc_ack",  32'(bif.oHOST_ACK), 32'd0);
    tick;
    chk("h_wait_ack",   32'(bif.oHOST_ACK), 32'd1);
    chk("h_wait_rdata", 32'(bif.oHOST_RDATA), 32'(pat(19'h12345)));
    bif.iHOST_REQ = 1'b0;
    tick;
    chk("h_ack_once", 32'(bif.oHOST_ACK), 32'd0);
    chk("h_idle",     32'(busy), 32'd0);
    tick;
    chk("opp_busy", 32'(busy), 32'd1);
    chk("opp_addr", 32'(bif.oMEM_ADDR), 32'd16);
    level = 10'd500;
    for (int i = 1; i < 16; i++) begin
      tick;
      chk("opp_addr", 32'(bif.oMEM_ADDR), 32'(16 + i));
    end
    tick; tick;
    chk("opp_done", 32'(busy), 32'd0);

    // Urgent level with host pending: display first, then host.
    level = 10'd30;
    bif.iHOST_REQ = 1'b1; bif.iHOST_WE = 1'b1; bif.iHOST_ADDR = 19'h00100; bif.iHOST_WDATA = 16'hBEEF;
    tick;
    chk("arb_disp_first", 32'(busy), 32'd1);
    chk("arb_addr",       32'(bif.oMEM_ADDR), 32'd32);
    chk("arb_we",         32'(bif.oMEM_WE), 32'd0);
    level = 10'd100;
    for (int i = 1; i < 16; i++) begin
      tick;
      chk("arb_addr", 32'(bif.oMEM_ADDR), 32'(32 + i));
    end
    tick;
    chk("arb_gap", 32'(busy), 32'd0);
    tick;
    chk("arb_host_addr",  32'(bif.oMEM_ADDR), 32'h100);
    chk("arb_host_we",    32'(bif.oMEM_WE), 32'd1);
    chk("arb_host_wdata", 32'(bif.oMEM_WDATA), 32'hBEEF);
    tick;
    chk("arb_host_ack", 32'(bif.oHOST_ACK), 32'd1);
    chk("arb_wait_we",  32'(bif.oMEM_WE), 32'd0);
    bif.iHOST_REQ = 1'b0; bif.iHOST_WE = 1'b0; level = 10'd500;
    tick;
    chk("arb_idle", 32'(busy), 32'd0);
    tick;
    bif.iHOST_REQ = 1'b1; bif.iHOST_ADDR = 19'h00100;
    tick;
    chk("rb_we", 32'(bif.oMEM_WE), 32'd0);
    tick;
    chk("rb_ack",   32'(bif.oHOST_ACK), 32'd1);
    chk("rb_rdata", 32'(bif.oHOST_RDATA), 32'hBEEF);
    bif.iHOST_REQ = 1'b0;
    tick; tick;

    // Vsync during a burst: old addresses complete, next burst from 0.
    level = 10'd10;
    tick;
    chk("vs_addr", 32'(bif.oMEM_ADDR), 32'd48);
    level = 10'd500;
    for (int i = 1; i < 16; i++) begin
      tick;
      vsync = (i == 4);
      chk("vs_addr", 32'(bif.oMEM_ADDR), 32'(48 + i));
    end
    tick;
    vsync = 1'b0;
    chk("vs_service_idle", 32'(busy), 32'd0);
    level = 10'd10;
    tick;
    chk("vs_idle2", 32'(busy), 32'd0);
    tick;
    chk("vs_restart_busy", 32'(busy), 32'd1);
    chk("vs_restart_addr", 32'(bif.oMEM_ADDR), 32'd0);
    level = 10'd500;

    // Reset in burst cycle 8.
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk("rs_addr", 32'(bif.oMEM_ADDR), 32'(i));
    end
    rst = 1'b1;
    tick;
    chk("rs_busy",    32'(busy), 32'd0);
    chk("rs_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rs_fdata",   32'(fifo_data), 32'd0);
    chk("rs_addr0",   32'(bif.oMEM_ADDR), 32'd0);
    chk("rs_we",      32'(bif.oMEM_WE), 32'd0);
    chk("rs_wdata",   32'(bif.oMEM_WDATA), 32'd0);
    chk("rs_ack",     32'(bif.oHOST_ACK), 32'd0);
    chk("rs_rdata",   32'(bif.oHOST_RDATA), 32'd0);
    rst = 1'b0; level = 10'd10;
    tick;
    chk("rs_restart_busy", 32'(busy), 32'd1);
    chk("rs_restart_addr", 32'(bif.oMEM_ADDR), 32'd0);
    level = 10'd500;
    for (int i = 1; i < 18; i++) tick;

    // End of frame on the 26-word instance.
    rst2 = 1'b0; level2 = 10'd0;
    tick;
    for (int i = 0; i < 16; i++) begin
      chk("fr_busy", 32'(busy2), 32'd1);
      chk("fr_addr", 32'(bif2.oMEM_ADDR), 32'(i));
      tick;
    end
    chk("fr_gap", 32'(busy2), 32'd0);
    tick;
    for (int i = 16; i < 26; i++) begin
      chk("fr_addr", 32'(bif2.oMEM_ADDR), 32'(i));
      tick;
    end
    chk("fr_stop",      32'(busy2), 32'd0);
    chk("fr_wr_last",   32'(fifo_wr2), 32'd1);
    chk("fr_data_last", 32'(fifo_data2), 32'(pat(19'd25)));
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (busy2) busy_cnt++;
    end
    chk("fr_no_fetch", 32'(busy_cnt), 32'd0);
    vsync2 = 1'b1;
    tick;
    vsync2 = 1'b0;
    tick;
    chk("fr_vs_idle", 32'(busy2), 32'd0);
    tick;
    chk("fr_vs_busy", 32'(busy2), 32'd1);
    chk("fr_vs_addr", 32'(bif2.oMEM_ADDR), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
